// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - UART state encoding and frame-level constants shared by tx and rx
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_tx_if.sv
// rtl/uart_tx_if.sv - byte handshake between an upstream source and the UART transmitter
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_gen.sv
// rtl/uart_baud_gen.sv - CLKS_PER_BIT divider; bit_end on the last cycle of each bit period
module uart_baud_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_end,
    output logic bit_pre_end
);
    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] PRE_LAST = CW'(CLKS_PER_BIT - 2);

    logic [CW-1:0] cnt;

    // clear wins over wrap so a frame always starts at phase 0
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (clear || bit_end) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign bit_end     = (cnt == LAST);
    assign bit_pre_end = (cnt == PRE_LAST);
endmodule

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmit serializer, LSB first, one stop bit
// Optional even parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic       clk,
    input  logic       reset,
    uart_tx_if.slave   tx_if,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    uart_state_t          state, state_next;
    logic [DATA_BITS-1:0] shreg;
    logic [BW-1:0]        bit_cnt;
    logic                 accept;
    logic                 bit_end, bit_pre_end;
    logic                 tx_d, busy_d, done_d;
`ifdef UART_TX_PARITY_EN
    logic                 parity_q;
`endif

    assign tx_if.tx_ready = (state == IDLE);
    assign accept         = tx_if.tx_valid && (state == IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk        (clk),
        .reset      (reset),
        .clear      (accept),
        .bit_end    (bit_end),
        .bit_pre_end(bit_pre_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_d       = IDLE_LEVEL;
        case (state)
            IDLE:   if (accept)  state_next = START;
            START:  if (bit_end) state_next = DATA;
            DATA: begin
                if (bit_end && (bit_cnt == LAST_BIT)) begin
`ifdef UART_TX_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = STOP;
`endif
                end
            end
            PARITY: if (bit_end) state_next = STOP;
            STOP:   if (bit_end) state_next = IDLE;
            default: state_next = IDLE;
        endcase

        // tx is registered, so it is driven from the state being entered;
        // mid-DATA bit boundaries present the bit about to be shifted down
        case (state_next)
            IDLE:   tx_d = IDLE_LEVEL;
            START:  tx_d = START_BIT;
            DATA:   tx_d = (state == DATA && bit_end) ? shreg[1] : shreg[0];
`ifdef UART_TX_PARITY_EN
            PARITY: tx_d = parity_q;
`endif
            STOP:   tx_d = STOP_BIT;
            default: tx_d = IDLE_LEVEL;
        endcase

        busy_d = (state_next != IDLE);
        done_d = (state == STOP) && bit_pre_end;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx       <= IDLE_LEVEL;
            tx_busy  <= 1'b0;
            tx_done  <= 1'b0;
            shreg    <= '0;
            bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            tx      <= tx_d;
            tx_busy <= busy_d;
            tx_done <= done_d;
            if (accept) begin
                shreg    <= tx_if.tx_data;
                bit_cnt  <= '0;
`ifdef UART_TX_PARITY_EN
                parity_q <= ^tx_if.tx_data;
`endif
            end else if (state == DATA && bit_end) begin
                shreg   <= shreg >> 1;
                bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BW'(1);
            end
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - scoreboard bench for uart_tx; per-cycle line model from the frame rules
module tb_uart_tx;
    localparam int CPB = 4;
    localparam int DB  = 8;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = DB + 3;
`else
    localparam int NBITS = DB + 2;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic tx, tx_busy, tx_done;
    int   checks = 0;
    int   failures = 0;
    int   edge_n = 0;

    typedef struct {
        logic [7:0] d;
        int         acc;
    } frame_t;
    frame_t sb[$];

    uart_tx_if #(.DATA_BITS(DB)) bus ();

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS   (DB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .tx_if  (bus),
        .tx     (tx),
        .tx_busy(tx_busy),
        .tx_done(tx_done)
    );

    always #5 clk = ~clk;
    always @(posedge clk) edge_n++;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at edge %0d", name, act, exp, edge_n);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Frame bit idx: 0 start, 1..DB data LSB first, then parity (if enabled), then stop
    function automatic logic exp_bit(input logic [7:0] d, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= DB) return d[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == DB + 1) return ^d;
`endif
        return 1'b1;
    endfunction

    // Cycle k of a frame is the period after edge acc+k-1; k=1..NBITS*CPB
    always @(negedge clk) begin
        logic e_tx, e_busy, e_done, e_ready;
        int   k;
        e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0; e_ready = 1'b1;
        if (sb.size() > 0 && edge_n >= sb[0].acc) begin
            k       = edge_n - sb[0].acc + 1;
            e_tx    = exp_bit(sb[0].d, (k - 1) / CPB);
            e_busy  = 1'b1;
            e_ready = 1'b0;
            e_done  = (k == NBITS * CPB);
            if (e_done) void'(sb.pop_front());
        end
        chk("tx", tx, e_tx);
        chk("tx_busy", tx_busy, e_busy);
        chk("tx_done", tx_done, e_done);
        chk("tx_ready", bus.tx_ready, e_ready);
    end

    task automatic send(input logic [7:0] d, output int acc);
        int t;
        @(negedge clk);
        bus.tx_data  = d;
        bus.tx_valid = 1'b1;
        t = 0;
        while (!bus.tx_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("accept_in_time", (t < 100), 1'b1);
        if (t < 100) begin
            acc = edge_n + 1;
            sb.push_back('{d, acc});
        end else begin
            acc = -1;
        end
        @(posedge clk);
    endtask

    task automatic drop_valid();
        @(negedge clk);
        bus.tx_valid = 1'b0;
        bus.tx_data  = 8'($urandom);
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() > 0 && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("drain_in_time", (t < 200), 1'b1);
        @(negedge clk);
    endtask

    initial begin
        int a, a1, a2;
        bus.tx_valid = 1'b0;
        bus.tx_data  = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_tx", tx, 1'b1);
        chk("reset_ready", bus.tx_ready, 1'b1);
        chk("reset_busy", tx_busy, 1'b0);
        chk("reset_done", tx_done, 1'b0);

        send(8'hA5, a); drop_valid(); drain();
`ifdef UART_TX_PARITY_EN
        send(8'h01, a); drop_valid(); drain();
`endif

        // held valid, data changed mid-frame to the next byte
        send(8'h3C, a1); send(8'hC3, a2); drop_valid(); drain();
        chk_int("b2b_gap", a2 - a1, NBITS * CPB + 1);

        // abort at cycle 12 (a data bit that is 0 for 0xA5)
        send(8'hA5, a); drop_valid();
        while (edge_n < a + 11) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_tx", tx, 1'b1);
        chk("abort_done", tx_done, 1'b0);
        chk("abort_busy", tx_busy, 1'b0);
        sb.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        send(8'h55, a); drop_valid(); drain();

        send(8'h00, a); drop_valid(); drain();
        send(8'hFF, a); drop_valid(); drain();

        repeat (12) begin
            send(8'($urandom), a);
            if ($urandom_range(0, 1) == 1) drop_valid();
        end
        drop_valid();
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
endmodule
